display_scan_7seg: RTL and testbench
====================================

# display_scan_7seg

Parametrised, time-multiplexed multi-digit 7-segment driver with per-digit parity checking. Each digit carries a 5-bit glyph code plus an even-parity bit, latched into a shadow bank on a load strobe. Digits are scanned one at a time onto a shared segment bus. A parity failure replaces that digit with a blinking 'E' and raises error flags. It sits between the datapath that produces display codes and the board's common-segment display.

## Interface
- N_DIGITS, 4, number of digits scanned; legal range 1..8
- SCAN_DIV, 1000, clock cycles each digit stays enabled; must be ≥1
- BLINK_FRAMES, 64, full scan frames per blink half-period; must be ≥1
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  capture strobe for code_in/par_in
- code_in  in  5*N_DIGITS  glyph codes; digit k = code_in[5k+4:5k], bit 5k+4 is MSB (b1)
- par_in  in  N_DIGITS  parity bit per digit (b_par)
- clr_err  in  1  clears err_sticky
- seg  out  7  {A,B,C,D,E,F,G}, seg[6]=A, active-high
- dig_en  out  N_DIGITS  one-hot digit enable, active-high
- err_vec  out  N_DIGITS  per-digit parity error of current bank
- err_sticky  out  1  set on any loaded parity error until cleared

## Operation
- Parity: digit valid iff XOR of its 5 code bits and par bit is 0 (even parity over 6 bits).
- Bank: on a clk edge with load=1, store all codes and err bits (err=parity fail) for all digits simultaneously. load=0 holds the bank.
- Glyph map for valid digits:
  - 0x00–0x0F: hex 0–F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
  - 0x10 blank 0000000.
  - 0x11 '-' 0000001.
  - 0x12–0x1F blank.
- Error digits: show 1001111 while blink_phase=1 and 0000000 while blink_phase=0. Valid digits never blink.
- Scan counter counts 0..SCAN_DIV-1.
  - At terminal count: the counter wraps to 0 and the digit index advances (N_DIGITS-1 wraps to 0).
- Frame: one pass of all N_DIGITS slots.
  - A frame counter counts 0..BLINK_FRAMES-1, incrementing when the index wraps to 0.
  - When it wraps, blink_phase toggles.
- err_sticky:
  - Set on any load edge that stores at least one error.
  - Cleared by clr_err=1.
  - If load-with-error and clr_err occur on the same edge, set wins.
  - clr_err does not alter err_vec.

## Timing
- Reset values (asserted asynchronously, immediately on rst_n=0):
  - seg=0, dig_en=0, err_vec=0, err_sticky=0.
  - Index, scan counter and frame counter = 0; blink_phase=1.
  - Bank codes=0x10 (blank), bank err=0.
- Outputs are registered.
  - seg/dig_en reflect the index and bank as they were before the edge.
  - First edge after rst_n deasserts: dig_en=...0001, seg=0000000.
- Load latency:
  - Edge n captures the bank; err_vec and err_sticky update at edge n.
  - seg reflects the new bank from edge n+1 onward.
- Each digit slot is exactly SCAN_DIV cycles of dig_en.
- Scanning is never paused by load or clr_err.
- SCAN_DIV=1: index advances every cycle.
- N_DIGITS=1: dig_en stays 1 permanently; the frame counter advances every SCAN_DIV cycles.
- Blink half-period = BLINK_FRAMES*N_DIGITS*SCAN_DIV cycles.
- Reset mid-scan: all state returns to reset values immediately. The bank is lost, so a reload is required.

## Test plan
Parameters for all scenarios: N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.

- **Reset:** hold rst_n=0, then release.
  - While low: seg=0, dig_en=0000, err_vec=0000, err_sticky=0.
  - First edge after release: dig_en=0001, seg=0000000.
- **Valid load and scan:** load codes {d0..d3}=1,2,3,4 with par=1,1,0,1.
  - err_vec=0000.
  - From the next edge: dig_en=0001 with seg=0110000 for 4 cycles.
  - Then 0010/1101101, 0100/1111001, 1000/0110011.
  - Back to 0001 after 16 cycles.
- **Parity error and blink:** load d2=0x03 with par=1, others valid.
  - err_vec=0100 and err_sticky=1 at the load edge.
  - Slot 2 shows 1001111 for frames 0–1 and 0000000 for frames 2–3, toggling every 32 cycles.
  - Other digits are steady.
- **Sticky clear:**
  - clr_err alone gives err_sticky=0 on the next edge, with err_vec unchanged at 0100.
  - clr_err on the same edge as an erroneous load leaves err_sticky=1.
- **Glyph edges:** codes 0x10 (par 1), 0x11 (par 0), 0x1F (par 1), 0x0B (par 1) display 0000000, 0000001, 0000000, 0011111 respectively.
- **Reset mid-scan:** drop rst_n during slot 2 of a loaded bank.
  - Outputs go to 0 without waiting for a clock edge.
  - After release: dig_en=0001, all digits blank, err_vec=0000.

Source files
------------

// File: rtl/display_scan_7seg.sv
// display_scan_7seg: time-multiplexed 7-segment driver with per-digit even-parity
// checking; a digit that fails parity is replaced by a blinking 'E'.
module display_scan_7seg #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [5*N_DIGITS-1:0]   code_in,
  input  logic [N_DIGITS-1:0]     par_in,
  input  logic                    clr_err,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     dig_en,
  output logic [N_DIGITS-1:0]     err_vec,
  output logic                    err_sticky
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
  logic [IW-1:0]       idx;
  logic [SW-1:0]       scan_cnt;
  logic [FW-1:0]       frame_cnt;
  logic                blink_phase;
  logic [4:0]          bank [N_DIGITS];
  logic [N_DIGITS-1:0] new_err;
  logic [6:0]          seg_nxt;
  logic                scan_tc, idx_tc, frame_tc;
  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      5'h00: glyph = 7'b1111110;
      5'h01: glyph = 7'b0110000;
      5'h02: glyph = 7'b1101101;
      5'h03: glyph = 7'b1111001;
      5'h04: glyph = 7'b0110011;
      5'h05: glyph = 7'b1011011;
      5'h06: glyph = 7'b1011111;
      5'h07: glyph = 7'b1110000;
      5'h08: glyph = 7'b1111111;
      5'h09: glyph = 7'b1111011;
      5'h0A: glyph = 7'b1110111;
      5'h0B: glyph = 7'b0011111;
      5'h0C: glyph = 7'b1001110;
      5'h0D: glyph = 7'b0111101;
      5'h0E: glyph = 7'b1001111;
      5'h0F: glyph = 7'b1000111;
      5'h11: glyph = 7'b0000001;
      default: glyph = 7'b0000000;
    endcase
  endfunction
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_par
    assign new_err[i] = ^{code_in[5*i +: 5], par_in[i]};
  end
  assign scan_tc  = scan_cnt == SCAN_MAX;
  assign idx_tc   = idx == IDX_MAX;
  assign frame_tc = frame_cnt == FRAME_MAX;
  // Outputs are built from the pre-edge index and bank, giving one cycle of latency.
  always_comb begin
    seg_nxt = err_vec[idx] ? (blink_phase ? 7'b1001111 : 7'b0000000) : glyph(bank[idx]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      scan_cnt    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      seg         <= '0;
      dig_en      <= '0;
      err_vec     <= '0;
      err_sticky  <= 1'b0;
      for (int k = 0; k < N_DIGITS; k++) bank[k] <= 5'h10;
    end else begin
      seg      <= seg_nxt;
      dig_en   <= N_DIGITS'(1) << idx;
      scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
      if (scan_tc) begin
        idx <= idx_tc ? '0 : idx + 1'b1;
        if (idx_tc) begin
          frame_cnt <= frame_tc ? '0 : frame_cnt + 1'b1;
          if (frame_tc) blink_phase <= ~blink_phase;
        end
      end
      if (load) begin
        err_vec <= new_err;
        for (int k = 0; k < N_DIGITS; k++) bank[k] <= code_in[5*k +: 5];
      end
      err_sticky <= (load && |new_err) || (err_sticky && !clr_err);
    end
  end
endmodule

// File: tb/tb_display_scan_7seg.sv
// tb_display_scan_7seg: scoreboarded bench; a time-based reference model predicts every
// output cycle and a negedge monitor compares the DUT against the queued expectations.
module tb_display_scan_7seg;
  localparam int N = 4, SD = 4, BF = 2;
  logic        clk = 1'b0, rst_n = 1'b1, load = 1'b0, clr_err = 1'b0;
  logic [19:0] code_in = '0;
  logic [3:0]  par_in = '0;
  logic [6:0]  seg;
  logic [3:0]  dig_en, err_vec;
  logic        err_sticky;
  display_scan_7seg #(.N_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .code_in(code_in), .par_in(par_in),
    .clr_err(clr_err), .seg(seg), .dig_en(dig_en), .err_vec(err_vec), .err_sticky(err_sticky)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig_en;
    logic [3:0] err_vec;
    logic       err_sticky;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  logic [6:0] hex_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  int         m;
  logic [4:0] mcode [4];
  logic [3:0] merr;
  logic       msticky;
  function automatic logic [6:0] ref_glyph(input logic [4:0] c);
    return c < 5'd16 ? hex_tab[c[3:0]] : (c == 5'h11 ? 7'b0000001 : 7'b0000000);
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    m = 0;
    merr = '0;
    msticky = 1'b0;
    for (int k = 0; k < N; k++) mcode[k] = 5'h10;
  endtask
  // Edges since reset determine slot and blink phase directly.
  task automatic cyc(input logic ld, input logic [19:0] c, input logic [3:0] p, input logic clr);
    exp_t e;
    int   ix;
    logic ph, any;
    load = ld; code_in = c; par_in = p; clr_err = clr;
    @(posedge clk);
    ix = (m / SD) % N;
    ph = ((m / (SD * N * BF)) % 2) == 0;
    e.dig_en = 4'(1 << ix);
    e.seg = merr[ix] ? (ph ? 7'b1001111 : 7'b0000000) : ref_glyph(mcode[ix]);
    any = 1'b0;
    if (ld) begin
      for (int k = 0; k < N; k++) begin
        mcode[k] = c[5*k +: 5];
        merr[k] = ($countones({c[5*k +: 5], p[k]}) % 2) == 1;
        any |= merr[k];
      end
    end
    msticky = (ld && any) || (msticky && !clr);
    e.err_vec = merr;
    e.err_sticky = msticky;
    m++;
    q.push_back(e);
    #1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("seg", 32'(seg), 32'(e.seg));
        check("dig_en", 32'(dig_en), 32'(e.dig_en));
        check("err_vec", 32'(err_vec), 32'(e.err_vec));
        check("err_sticky", 32'(err_sticky), 32'(e.err_sticky));
      end
    end
  end
  task automatic check_zero(input string tag);
    check({tag, "_seg"}, 32'(seg), 0);
    check({tag, "_dig_en"}, 32'(dig_en), 0);
    check({tag, "_err_vec"}, 32'(err_vec), 0);
    check({tag, "_err_sticky"}, 32'(err_sticky), 0);
  endtask
  initial begin
    logic [19:0] c;
    logic [3:0]  p;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (3) cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b1, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1011, 1'b0);
    repeat (20) cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b1, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1111, 1'b0);
    repeat (80) cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1);
    repeat (3) cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b1, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1111, 1'b1);
    repeat (3) cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b1, {5'h0B, 5'h1F, 5'h11, 5'h10}, 4'b1101, 1'b0);
    repeat (20) cyc(1'b0, '0, '0, 1'b0);
    repeat (1200) begin
      c = 20'($urandom);
      for (int k = 0; k < N; k++) p[k] = (^c[5*k +: 5]) ^ (($urandom % 4) == 0);
      cyc(($urandom % 16) == 0, c, p, ($urandom % 10) == 0);
    end
    cyc(1'b1, {5'd7, 5'd8, 5'd9, 5'd5}, 4'b1010, 1'b0);
    for (int i = 0; i < 16 && ((m / SD) % N) != 3; i++) cyc(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) cyc(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
